trackball_reader: RTL and testbench

//  Parametrised quadrature/trackball motion counter: N clock/direction axes, synchronised and

---
 rtl/trackball_reader.sv | 120 ++++++++++++
 tb/tb_trackball_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trackball_reader.sv
// Quadrature/trackball motion counter: N clock/direction axes, synchronised, glitch-filtered,
// accumulated into per-axis counters and read out through a registered CPU read port.
module trackball_reader #(
  parameter int unsigned         NUM_AXES    = 4,
  parameter int unsigned         CNT_W       = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         FILTER_LEN  = 3,
  parameter bit                  SATURATE    = 1'b0,
  parameter bit                  CLR_ON_READ = 1'b0,
  parameter logic [NUM_AXES-1:0] INVERT      = '0,
  localparam int unsigned        SEL_W       = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_AXES-1:0] tb_clk,
  input  logic [NUM_AXES-1:0] tb_dir,
  input  logic                steerclr,
  input  logic                rd_en,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [7:0]          data_out,
  output logic                rd_valid
);

  localparam int unsigned LINES  = 2 * NUM_AXES;
  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned SEL_N  = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LINES-1:0]    sync_q [SYNC_STAGES];
  logic [LINES-1:0]    filt_q;
  logic [FCNT_W-1:0]   fcnt_q [LINES];
  logic [NUM_AXES-1:0] clk_prev_q;
  logic [NUM_AXES-1:0] dir_q;
  logic [NUM_AXES-1:0] step;
  logic [NUM_AXES-1:0] dir_now;
  logic [CNT_W-1:0]    cnt_q [NUM_AXES];
  logic [CNT_W-1:0]    cnt_d [NUM_AXES];
  logic [7:0]          word [SEL_N];

  // Synchroniser chain; lines packed as {dir, clk}
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {tb_dir, tb_clk};
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int l = 0; l < int'(LINES); l++) fcnt_q[l] <= '0;
    end else begin
      for (int l = 0; l < int'(LINES); l++) begin
        if (sync_q[SYNC_STAGES-1][l] != filt_q[l]) begin
          if (fcnt_q[l] == FCNT_W'(FILTER_LEN - 1)) begin
            filt_q[l] <= sync_q[SYNC_STAGES-1][l];
            fcnt_q[l] <= '0;
          end else begin
            fcnt_q[l] <= fcnt_q[l] + FCNT_W'(1);
          end
        end else begin
          fcnt_q[l] <= '0;
        end
      end
    end
  end

  assign step    = filt_q[NUM_AXES-1:0] & ~clk_prev_q;
  assign dir_now = filt_q[LINES-1:NUM_AXES] ^ INVERT;

  // Next count: a clear zeroes the base, a same-cycle step is still applied on top of it
  always_comb begin
    for (int i = 0; i < int'(NUM_AXES); i++) begin
      cnt_d[i] = cnt_q[i];
      if (steerclr || (CLR_ON_READ && rd_en && rd_sel == SEL_W'(i))) cnt_d[i] = '0;
      if (step[i]) begin
        if (dir_now[i]) begin
          if (!(SATURATE && cnt_d[i] == CNT_MAX)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end else begin
          if (!(SATURATE && cnt_d[i] == '0)) cnt_d[i] = cnt_d[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_q <= '0;
      dir_q      <= '0;
      for (int i = 0; i < int'(NUM_AXES); i++) cnt_q[i] <= '0;
    end else begin
      clk_prev_q <= filt_q[NUM_AXES-1:0];
      dir_q      <= (dir_q & ~step) | (dir_now & step);
      for (int i = 0; i < int'(NUM_AXES); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read words for every encodable select; unpopulated selects read as zero
  always_comb begin
    for (int k = 0; k < int'(SEL_N); k++) word[k] = '0;
    for (int i = 0; i < int'(NUM_AXES); i++) begin
      word[i][7]         = dir_q[i];
      word[i][CNT_W-1:0] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= word[rd_sel];
    end
  end

endmodule

// File: tb/tb_trackball_reader.sv
// Bench for trackball_reader: two differently parameterised instances, directed scenarios plus
// random line activity, compared every cycle against a window-based behavioural model.
module tb_trackball_reader;

  logic       clk;
  logic       reset;
  logic [3:0] raw_clk;
  logic [3:0] raw_dir;
  logic       steerclr;
  logic       rd_en;
  logic [1:0] rd_sel;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;

  int n_vectors;
  int n_miscompares;

  trackball_reader #(
    .NUM_AXES(4), .CNT_W(4), .SYNC_STAGES(2), .FILTER_LEN(3),
    .SATURATE(1'b0), .CLR_ON_READ(1'b0), .INVERT(4'b0000)
  ) dut_a (
    .clk(clk), .reset(reset), .tb_clk(raw_clk), .tb_dir(raw_dir),
    .steerclr(steerclr), .rd_en(rd_en), .rd_sel(rd_sel),
    .data_out(data_a), .rd_valid(valid_a)
  );

  trackball_reader #(
    .NUM_AXES(3), .CNT_W(3), .SYNC_STAGES(3), .FILTER_LEN(2),
    .SATURATE(1'b1), .CLR_ON_READ(1'b1), .INVERT(3'b100)
  ) dut_b (
    .clk(clk), .reset(reset), .tb_clk(raw_clk[2:0]), .tb_dir(raw_dir[2:0]),
    .steerclr(steerclr), .rd_en(rd_en), .rd_sel(rd_sel),
    .data_out(data_b), .rd_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model configuration, index 0 = dut_a, 1 = dut_b
  localparam int M_NA  [2] = '{4, 3};
  localparam int M_CW  [2] = '{4, 3};
  localparam int M_SS  [2] = '{2, 3};
  localparam int M_FL  [2] = '{3, 2};
  localparam int M_SAT [2] = '{0, 1};
  localparam int M_COR [2] = '{0, 1};
  localparam int M_INV [2] = '{0, 4};

  int         m_cnt   [2][4];
  bit         m_dirl  [2][4];
  bit         m_prev  [2][4];
  bit         m_filt  [2][8];
  logic [7:0] m_data  [2];
  bit         m_valid [2];
  logic [7:0] hist    [16];

  // Filter modelled as "last FILTER_LEN synced samples all disagree with the accepted level"
  always @(posedge clk) begin : model
    int v;
    int m;
    int l;
    bit up;
    bit all_diff;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i] = 0; m_dirl[d][i] = 0; m_prev[d][i] = 0;
        end
        for (int k = 0; k < 8; k++) m_filt[d][k] = 0;
        m_data[d] = 8'h00;
        m_valid[d] = 0;
      end
      for (int k = 0; k < 16; k++) hist[k] = 8'h00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = rd_en;
        if (rd_en) begin
          if (int'(rd_sel) < M_NA[d]) begin
            m_data[d] = 8'(m_cnt[d][rd_sel]);
            m_data[d][7] = m_dirl[d][rd_sel];
          end else begin
            m_data[d] = 8'h00;
          end
        end
        m = 1 << M_CW[d];
        for (int i = 0; i < M_NA[d]; i++) begin
          v = (steerclr || (M_COR[d] != 0 && rd_en && int'(rd_sel) == i)) ? 0 : m_cnt[d][i];
          if (m_filt[d][i] && !m_prev[d][i]) begin
            up = m_filt[d][4+i] ^ M_INV[d][i];
            v = up ? v + 1 : v - 1;
            if (M_SAT[d] != 0) begin
              if (v > m - 1) v = m - 1;
              if (v < 0) v = 0;
            end else begin
              v = (v + m) % m;
            end
            m_dirl[d][i] = up;
          end
          m_cnt[d][i] = v;
        end
        for (int i = 0; i < M_NA[d]; i++) m_prev[d][i] = m_filt[d][i];
        for (int i = 0; i < M_NA[d]; i++) begin
          for (int j = 0; j < 2; j++) begin
            l = (j == 0) ? i : 4 + i;
            all_diff = 1;
            for (int k = 0; k < M_FL[d]; k++)
              if (hist[M_SS[d] - 1 + k][l] == m_filt[d][l]) all_diff = 0;
            if (all_diff) m_filt[d][l] = !m_filt[d][l];
          end
        end
      end
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {raw_dir, raw_clk};
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("data_a", data_a, m_data[0]);
    check("valid_a", 8'(valid_a), 8'(m_valid[0]));
    check("data_b", data_b, m_data[1]);
    check("valid_b", 8'(valid_b), 8'(m_valid[1]));
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int ax, input int n);
    for (int p = 0; p < n; p++) begin
      raw_clk[ax] = 1'b1;
      settle(4);
      raw_clk[ax] = 1'b0;
      settle(4);
    end
    settle(8);
  endtask

  task automatic clear_all();
    steerclr = 1'b1;
    tick();
    steerclr = 1'b0;
    settle(2);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] ea, input logic [7:0] eb,
                    input bit chk_b, input string tag);
    rd_sel = sel;
    rd_en  = 1'b1;
    tick();
    rd_en  = 1'b0;
    check({tag, "_a"}, data_a, ea);
    check({tag, "_a_valid"}, 8'(valid_a), 8'h01);
    if (chk_b) check({tag, "_b"}, data_b, eb);
    tick();
    check({tag, "_valid_drop"}, 8'(valid_a), 8'h00);
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    reset = 1'b1;
    raw_clk = 4'b0000;
    raw_dir = 4'b0001;
    steerclr = 1'b0;
    rd_en = 1'b0;
    rd_sel = 2'd0;
    repeat (4) @(posedge clk);
    tick();
    check("rst_data_a", data_a, 8'h00);
    check("rst_valid_a", 8'(valid_a), 8'h00);
    check("rst_data_b", data_b, 8'h00);
    reset = 1'b0;
    settle(8);

    // Five clean pulses, direction up
    pulse(0, 5);
    rd(2'd0, 8'h85, 8'h85, 1, "t1_five_up");

    // Three down pulses: wrap vs saturate
    raw_dir[1] = 1'b0;
    settle(8);
    pulse(1, 3);
    rd(2'd1, 8'h0D, 8'h00, 1, "t2_down3");

    // Short glitch rejected by the length-3 filter, full pulse accepted
    raw_dir[2] = 1'b1;
    settle(8);
    raw_clk[2] = 1'b1;
    settle(2);
    raw_clk[2] = 1'b0;
    settle(10);
    rd(2'd2, 8'h00, 8'h00, 0, "t3_glitch");
    pulse(2, 1);
    rd(2'd2, 8'h81, 8'h00, 0, "t3_pulse");

    // Clear coinciding with a +1 step (6-cycle latency on both instances)
    raw_dir[3] = 1'b1;
    settle(8);
    raw_clk[0] = 1'b1;
    settle(5);
    steerclr = 1'b1;
    tick();
    steerclr = 1'b0;
    raw_clk[0] = 1'b0;
    settle(8);
    pulse(3, 1);
    rd(2'd0, 8'h81, 8'h81, 1, "t4_ax0");
    rd(2'd1, 8'h00, 8'h00, 0, "t4_ax1");
    rd(2'd2, 8'h80, 8'h00, 0, "t4_ax2");
    rd(2'd3, 8'h81, 8'h00, 0, "t4_ax3");

    // Read-and-clear, including a read landing on the same cycle as a step
    clear_all();
    pulse(0, 7);
    rd(2'd0, 8'h87, 8'h87, 1, "t5_read7");
    rd(2'd0, 8'h87, 8'h80, 1, "t5_reread");
    pulse(0, 7);
    raw_clk[0] = 1'b1;
    settle(5);
    rd_sel = 2'd0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_rdstep_a", data_a, 8'h8E);
    check("t5_rdstep_b", data_b, 8'h87);
    raw_clk[0] = 1'b0;
    settle(8);
    rd(2'd0, 8'h8F, 8'h81, 1, "t5_after");

    // Inverted axis on dut_b, out-of-range select, reset during a read
    clear_all();
    raw_dir[2] = 1'b0;
    settle(8);
    pulse(2, 3);
    raw_dir[2] = 1'b1;
    settle(8);
    pulse(2, 1);
    rd(2'd2, 8'h8E, 8'h02, 1, "t6_invert");
    rd(2'd3, 8'h80, 8'h00, 1, "t6_badsel");
    rd_sel = 2'd0;
    rd_en = 1'b1;
    reset = 1'b1;
    tick();
    check("t6_rst_valid_a", 8'(valid_a), 8'h00);
    check("t6_rst_data_a", data_a, 8'h00);
    check("t6_rst_valid_b", 8'(valid_b), 8'h00);
    check("t6_rst_data_b", data_b, 8'h00);
    rd_en = 1'b0;
    settle(3);
    reset = 1'b0;
    settle(8);

    // Random line activity, clears, reads and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        settle(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) raw_clk[b] = ~raw_clk[b];
        if ($urandom_range(0, 7) == 0) raw_dir[b] = ~raw_dir[b];
      end
      steerclr = ($urandom_range(0, 24) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
